// File: rtl/imem_loader.sv
// Byte-stream loader for instruction memory: 16-bit word-count header, then little-endian words.
// Holds the core in reset until the image lands; a start pulse re-arms from DONE/ERR.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  localparam int MAX_WORDS = 2 ** ADDR_W;

  typedef enum logic [2:0] {HDR0, HDR1, DATA, DONE, ERR} state_t;

  state_t            state, state_nxt;
  logic [15:0]       count;
  logic [1:0]        byte_idx;
  logic [ADDR_W:0]   word_cnt;   // one extra bit so a full image never wraps
  logic [23:0]       lanes;
  logic              hs;
  logic [15:0]       hdr_n;
  logic              last_word;

  assign in_ready  = reset && (state == HDR0 || state == HDR1 || state == DATA);
  assign hs        = in_valid && in_ready;
  assign hdr_n     = {in_data, count[7:0]};
  assign last_word = ({{(16-ADDR_W){1'b0}}, word_cnt} == ({1'b0, count} - 17'd1));
  assign done      = (state == DONE);
  assign error     = (state == ERR);

  always_ff @(posedge clk) begin
    if (!reset) state <= HDR0;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HDR0: if (hs) state_nxt = HDR1;
      HDR1: begin
        if (hs) begin
          if (hdr_n == 16'd0)                         state_nxt = DONE;
          else if ({1'b0, hdr_n} > 17'(MAX_WORDS))    state_nxt = ERR;
          else                                        state_nxt = DATA;
        end
      end
      DATA: if (hs && byte_idx == 2'd3 && last_word) state_nxt = DONE;
      DONE: if (start) state_nxt = HDR0;
      ERR:  if (start) state_nxt = HDR0;
      default: state_nxt = HDR0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count     <= '0;
      byte_idx  <= '0;
      word_cnt  <= '0;
      lanes     <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      cpu_reset <= 1'b1;
    end else begin
      wr_en <= 1'b0;
      case (state)
        HDR0: if (hs) count[7:0]  <= in_data;
        HDR1: if (hs) count[15:8] <= in_data;
        DATA: begin
          if (hs) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: lanes[7:0]   <= in_data;
              2'd1: lanes[15:8]  <= in_data;
              2'd2: lanes[23:16] <= in_data;
              default: begin
                wr_en    <= 1'b1;
                wr_data  <= {in_data, lanes};
                wr_addr  <= word_cnt[ADDR_W-1:0];
                word_cnt <= word_cnt + 1'b1;
              end
            endcase
          end
        end
        DONE, ERR: begin
          if (start) begin
            cpu_reset <= 1'b1;
            byte_idx  <= '0;
            word_cnt  <= '0;
            wr_addr   <= '0;
          end else if (state == DONE) begin
            // Released one cycle after DONE so the final write is already in memory.
            cpu_reset <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
